// File: rtl/ifetch_pipe.sv
// Pipelined instruction fetch: PC, one-cycle-latency memory requests, DEPTH-entry queue to decode.
// Optional IFETCH_PERF_EN adds fetch and bubble performance counters.
module ifetch_pipe #(
  parameter int unsigned       WIDTH    = 32,
  parameter int unsigned       STEP     = 1,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCSrc,
  input  logic [WIDTH-1:0] BrDest,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             if_valid,
  input  logic             id_ready,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] nPC
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_bubble_cnt
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] StepW = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_q;
  logic             inflight_q;
  logic [WIDTH-1:0] tag_q;
  logic [WIDTH-1:0] ir_mem_q  [DEPTH];
  logic [WIDTH-1:0] npc_mem_q [DEPTH];
  logic [PtrW-1:0]  head_q, tail_q;
  logic [OccW-1:0]  occ_q;
  logic [WIDTH-1:0] last_ir_q, last_npc_q;

  logic             pop, push;
  logic [OccW:0]    demand;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign if_valid  = (occ_q != '0);
  assign pop       = if_valid & id_ready;
  // A redirect kills the response landing this cycle; no request is issued alongside it.
  assign push      = inflight_q & ~PCSrc;
  assign demand    = {1'b0, occ_q} + (OccW+1)'(inflight_q) - (OccW+1)'(pop);
  assign imem_req  = reset & ~PCSrc & (demand < (OccW+1)'(DEPTH));
  assign imem_addr = pc_q;
  // When empty, show the last consumed instruction rather than a stale slot.
  assign IR        = if_valid ? ir_mem_q[head_q]  : last_ir_q;
  assign nPC       = if_valid ? npc_mem_q[head_q] : last_npc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      last_ir_q  <= '0;
      last_npc_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ir_mem_q[i]  <= '0;
        npc_mem_q[i] <= '0;
      end
    end else begin
      inflight_q <= imem_req;
      if (imem_req) begin
        pc_q  <= pc_q + StepW;
        tag_q <= pc_q + StepW;
      end else if (PCSrc) begin
        pc_q <= BrDest;
      end

      if (pop) begin
        last_ir_q  <= ir_mem_q[head_q];
        last_npc_q <= npc_mem_q[head_q];
      end

      if (PCSrc) begin
        head_q <= '0;
        tail_q <= '0;
        occ_q  <= '0;
      end else begin
        if (push) begin
          ir_mem_q[tail_q]  <= imem_rdata;
          npc_mem_q[tail_q] <= tag_q;
          tail_q            <= ptr_inc(tail_q);
        end
        if (pop) head_q <= ptr_inc(head_q);
        occ_q <= occ_q + OccW'(push) - OccW'(pop);
      end
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (id_ready && !if_valid) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_pipe.sv
// Scoreboard bench for ifetch_pipe: stimulus loads expected IR/nPC words, a negedge monitor checks pops.
module tb_ifetch_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PCSrc = 1'b0;
  logic        id_ready = 1'b0;
  logic [31:0] BrDest = '0;

  logic        req0, v0, req1, v1;
  logic [31:0] addr0, rdata0, ir0, npc0;
  logic [31:0] addr1, rdata1, ir1, npc1;
`ifdef IFETCH_PERF_EN
  logic [31:0] pf0, pb0, pf1, pb1;
  int          pf_m = 0;
  int          pb_m = 0;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  always #5 clk = ~clk;

  ifetch_pipe u0 (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .BrDest(BrDest),
    .imem_req(req0), .imem_addr(addr0), .imem_rdata(rdata0),
    .if_valid(v0), .id_ready(id_ready), .IR(ir0), .nPC(npc0)
`ifdef IFETCH_PERF_EN
    , .perf_fetch_cnt(pf0), .perf_bubble_cnt(pb0)
`endif
  );

  ifetch_pipe #(.RESET_PC(32'hFFFF_FFFF)) u1 (
    .clk(clk), .reset(reset), .PCSrc(1'b0), .BrDest(32'h0),
    .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
    .if_valid(v1), .id_ready(id_ready), .IR(ir1), .nPC(npc1)
`ifdef IFETCH_PERF_EN
    , .perf_fetch_cnt(pf1), .perf_bubble_cnt(pb1)
`endif
  );

  // Memory model: rdata = addr + 0x100, garbage when no request was made.
  always @(posedge clk) begin
    rdata0 <= req0 ? addr0 + 32'h100 : 32'hDEAD_BEEF;
    rdata1 <= req1 ? addr1 + 32'h100 : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
`ifdef IFETCH_PERF_EN
    if (!reset) begin
      pf_m = 0;
      pb_m = 0;
    end else if (id_ready && !v0) begin
      pb_m++;
    end
    if (reset && v0 && id_ready) pf_m++;
`endif
    if (reset && v0 && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got IR %h nPC %h, expected no word", ir0, npc0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_ir", ir0, mon_e[63:32]);
        chk("sb_npc", npc0, mon_e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] base, input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({base + 32'(k) + 32'h100, base + 32'(k) + 32'h1});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_ir", ir0, 32'h0);
    chk("rst_npc", npc0, 32'h0);
    chk("rst_req", 32'(req0), 32'd0);
    chk("rst_addr", addr0, 32'h0);
    chk("rst_addr_wrap", addr1, 32'hFFFF_FFFF);

    // Streaming from reset; the second instance checks PC wrap.
    load(32'h0, 200);
    id_ready = 1'b1;
    reset    = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("s1_addr", addr0, 32'(i));
      chk("s1_req", 32'(req0), 32'd1);
      chk("s1_valid", 32'(v0), (i >= 2) ? 32'd1 : 32'd0);
      chk("s6_addr", addr1, 32'hFFFF_FFFF + 32'(i));
      if (i == 2) begin
        chk("s6_ir", ir1, 32'h0000_00FF);
        chk("s6_npc", npc1, 32'h0);
      end
      tick();
    end
    repeat (3) tick();

    // Decode stall: head is word 5.
    id_ready = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("s2_valid", 32'(v0), 32'd1);
      chk("s2_ir", ir0, 32'h105);
      chk("s2_npc", npc0, 32'h6);
      chk("s2_req", 32'(req0), 32'd0);
      tick();
    end
    id_ready = 1'b1;
    repeat (4) tick();

    // Redirect with a queued word and an in-flight response.
    id_ready = 1'b0;
    PCSrc    = 1'b1;
    BrDest   = 32'h40;
    #1;
    chk("s3_req_in_redirect", 32'(req0), 32'd0);
    tick();
    load(32'h40, 50);
    PCSrc    = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("s3_valid_a", 32'(v0), 32'd0);
    chk("s3_addr", addr0, 32'h40);
    chk("s3_req", 32'(req0), 32'd1);
    tick();
    chk("s3_valid_b", 32'(v0), 32'd0);
    chk("s3_addr_b", addr0, 32'h41);
    tick();
    chk("s3_valid_c", 32'(v0), 32'd1);
    tick();
    tick();

    // Redirect in the same cycle as a pop.
    PCSrc  = 1'b1;
    BrDest = 32'h80;
    tick();
    load(32'h80, 50);
    PCSrc = 1'b0;
    #1;
    chk("s4_valid_a", 32'(v0), 32'd0);
    chk("s4_addr", addr0, 32'h80);
`ifdef IFETCH_PERF_EN
    chk("s4_perf_fetch", pf0, 32'(pf_m));
    chk("s4_perf_bubble", pb0, 32'(pb_m));
`endif
    tick();
    chk("s4_valid_b", 32'(v0), 32'd0);
    tick();
    chk("s4_valid_c", 32'(v0), 32'd1);
    repeat (3) tick();

    // Asynchronous reset in the middle of a cycle.
    #2;
    reset = 1'b0;
    #1;
    chk("s5_valid", 32'(v0), 32'd0);
    chk("s5_req", 32'(req0), 32'd0);
    chk("s5_addr", addr0, 32'h0);
    chk("s5_ir", ir0, 32'h0);
`ifdef IFETCH_PERF_EN
    chk("s5_perf_fetch", pf0, 32'h0);
`endif
    load(32'h0, 50);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("s5_addr_restart", addr0, 32'h0);
    chk("s5_req_restart", 32'(req0), 32'd1);
    repeat (6) tick();
    chk("s5_drain", 32'(exp_q.size()), 32'd46);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
